// File: rtl/uart_rx_frame_chk_if.sv
// Frame-level link between the RX bit sampler (master) and the frame checker (slave):
// per-bit strobes toward the checker, per-frame results back.
interface uart_rx_frame_chk_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  frame_start;
  logic                  bit_vld;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  frame_done;
  logic                  data_vld;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output frame_start, bit_vld, sampled_bit,
    input  P_DATA, frame_done, data_vld, par_err, stp_err
  );

  modport slave (
    input  frame_start, bit_vld, sampled_bit,
    output P_DATA, frame_done, data_vld, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_frame_chk.sv
// UART RX frame checker: assembles LSB-first data, checks parity and stop bits, reports per frame.
// Optional saturating error counters are built only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_rx_frame_chk_if.slave   bus,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 STOP2,
  input  logic                 clr_sts,
  output logic                 sts_par_err,
  output logic                 sts_stp_err,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stp_err_cnt
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP_A, S_STOP_B} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift, r_p_data;
  logic                  r_run_par, r_par_en, r_stop2;
  logic [1:0]            r_par_typ;
  logic                  r_par_fail, r_stp_fail;
  logic                  r_frame_done, r_data_vld, r_par_err, r_stp_err;
  logic                  w_finish, w_exp_par, w_stp_fail_fin;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // frame_start has priority over everything, including a same-cycle bit_vld
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_par_typ)
      2'b00:   w_exp_par = r_run_par;
      2'b01:   w_exp_par = ~r_run_par;
      2'b10:   w_exp_par = 1'b1;
      default: w_exp_par = 1'b0;
    endcase
    if (bus.frame_start) begin
      w_state_next = S_DATA;
    end else if (bus.bit_vld) begin
      case (r_state)
        S_DATA:   if (r_bit_cnt == CW'(DATA_WIDTH - 1))
                    w_state_next = r_par_en ? S_PARITY : S_STOP_A;
        S_PARITY: w_state_next = S_STOP_A;
        S_STOP_A: begin
          if (r_stop2) begin
            w_state_next = S_STOP_B;
          end else begin
            w_state_next = S_IDLE;
            w_finish     = 1'b1;
          end
        end
        S_STOP_B: begin
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The finishing bit is always a stop bit, so fold its value in directly
  assign w_stp_fail_fin = r_stp_fail | ~bus.sampled_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_run_par  <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 2'b00;
      r_stop2    <= 1'b0;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
    end else if (bus.frame_start) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_run_par  <= 1'b0;
      r_par_en   <= PAR_EN;
      r_par_typ  <= PAR_TYP;
      r_stop2    <= STOP2;
      r_par_fail <= 1'b0;
      r_stp_fail <= 1'b0;
    end else if (bus.bit_vld) begin
      case (r_state)
        S_DATA: begin
          r_shift   <= {bus.sampled_bit, r_shift[DATA_WIDTH-1:1]};
          r_run_par <= r_run_par ^ bus.sampled_bit;
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
        S_PARITY: if (bus.sampled_bit != w_exp_par) r_par_fail <= 1'b1;
        S_STOP_A, S_STOP_B: if (!bus.sampled_bit) r_stp_fail <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_frame_done <= 1'b0;
      r_data_vld   <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_p_data     <= '0;
    end else begin
      r_frame_done <= w_finish;
      r_data_vld   <= w_finish & ~(r_par_fail | w_stp_fail_fin);
      r_par_err    <= w_finish & r_par_fail;
      r_stp_err    <= w_finish & w_stp_fail_fin;
      if (w_finish) r_p_data <= r_shift;
    end
  end

  assign bus.P_DATA     = r_p_data;
  assign bus.frame_done = r_frame_done;
  assign bus.data_vld   = r_data_vld;
  assign bus.par_err    = r_par_err;
  assign bus.stp_err    = r_stp_err;

  // Channel 0 = parity, channel 1 = stop
  logic [1:0]           w_err_pulse, w_sts;
  logic [CNT_WIDTH-1:0] w_cnt [2];

  assign w_err_pulse = {r_stp_err, r_par_err};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic r_sts;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                 r_sts <= 1'b0;
      else if (w_err_pulse[gi]) r_sts <= 1'b1;
      else if (clr_sts)         r_sts <= 1'b0;
    end
    assign w_sts[gi] = r_sts;

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_cnt <= '0;
      end else if (w_err_pulse[gi]) begin
        if (clr_sts)     r_cnt <= CNT_WIDTH'(1);
        else if (!(&r_cnt)) r_cnt <= r_cnt + CNT_WIDTH'(1);
      end else if (clr_sts) begin
        r_cnt <= '0;
      end
    end
    assign w_cnt[gi] = r_cnt;
`else
    assign w_cnt[gi] = '0;
`endif
  end

  assign sts_par_err = w_sts[0];
  assign sts_stp_err = w_sts[1];
  assign par_err_cnt = w_cnt[0];
  assign stp_err_cnt = w_cnt[1];
endmodule

// File: doc/uart_rx_frame_chk.md
# uart_rx_frame_chk

Parametrised UART receive frame checker. It replaces the single-purpose parity checker in the UART RX path. Driven by the RX sampler, it assembles the data bits LSB-first and computes parity incrementally. It checks the configurable parity bit and one or two stop bits, then emits a one-cycle frame result with per-error pulses, sticky status and optional saturating error counters.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- CNT_WIDTH, 8, width of each error counter

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse: start bit confirmed by RX FSM
- bit_vld  in  1  one-cycle strobe: sampled_bit holds a resolved mid-bit sample
- sampled_bit  in  1  majority-voted bit value
- PAR_EN  in  1  parity bit present in frame
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
- STOP2  in  1  two stop bits expected
- clr_sts  in  1  clears sticky flags and counters
- P_DATA  out  DATA_WIDTH  received data, LSB = first data bit
- frame_done  out  1  one-cycle pulse: frame finished, outputs valid
- data_vld  out  1  one-cycle pulse with frame_done when no error
- par_err  out  1  one-cycle pulse with frame_done on parity mismatch
- stp_err  out  1  one-cycle pulse with frame_done on any stop bit = 0
- sts_par_err, sts_stp_err  out  1 each  sticky error flags
- par_err_cnt, stp_err_cnt  out  CNT_WIDTH each  saturating error counts (see Configuration)

## Operation
- FSM states: IDLE, DATA, PARITY, STOP_A, STOP_B.
- IDLE: frame_start -> DATA. Clears bit_cnt, shift register and running parity. Latches PAR_EN, PAR_TYP and STOP2 for the whole frame.
- DATA: each bit_vld shifts sampled_bit into the MSB of shift_reg (right shift) and sets run_par ^= sampled_bit.
- DATA exit: on the DATA_WIDTH-th bit_vld, go to PARITY if PAR_EN, else STOP_A.
- PARITY: on bit_vld, the expected bit is run_par (even), ~run_par (odd), 1 (mark) or 0 (space). A mismatch sets the par_fail flag. Then go to STOP_A.
- STOP_A: on bit_vld, sampled_bit = 0 sets stp_fail. Go to STOP_B if STOP2, else finish.
- STOP_B: on bit_vld, sampled_bit = 0 sets stp_fail. Then finish.
- Finish: return to IDLE and register the frame outputs:
  - P_DATA <= shift_reg, updated even when an error occurred
  - frame_done = 1
  - data_vld = ~(par_fail | stp_fail)
  - par_err = par_fail, stp_err = stp_fail
- P_DATA holds its value until the next finish.
- frame_start outside IDLE aborts the current frame silently (no outputs, no counts) and restarts in DATA.
- frame_start and bit_vld in the same cycle: frame_start wins; that bit_vld is ignored.
- bit_vld in IDLE is ignored.
- Sticky flags set on an error pulse and clear on clr_sts. If both happen in the same cycle, the set wins.
- Counters increment on an error pulse and saturate at all-ones. clr_sts zeroes them. Same-cycle clr_sts and error loads 1.

## Timing
- Final bit_vld in cycle N -> frame_done, data_vld, par_err, stp_err, P_DATA valid in cycle N+1. All are registered.
- Sticky flags and counters update in cycle N+2, registered from the pulses.
- Pulses last exactly one cycle. The earliest next frame_start is accepted in cycle N+1.
- Reset values:
  - all outputs 0, including P_DATA, sticky flags and counters
  - FSM in IDLE
  - internal registers 0
- Reset mid-frame discards the frame with no pulse.

## Configuration
- UART_RX_ERR_CNT_EN defined: par_err_cnt and stp_err_cnt are implemented as described.
- UART_RX_ERR_CNT_EN undefined: counter registers are removed; both ports are tied to 0. Sticky flags and pulses are unchanged.

## Test plan
- DATA_WIDTH=8, even parity, 1 stop, data 0xA5, parity 0, stop 1 -> next cycle P_DATA=0xA5, frame_done=1, data_vld=1, par_err=0, stp_err=0.
- Odd parity, data 0xA5, parity bit 0 -> par_err=1, data_vld=0, P_DATA=0xA5, sts_par_err=1, par_err_cnt=1.
- STOP2=1, PAR_EN=0, data 0x3C, stop bits 1 then 0 -> stp_err=1, data_vld=0. Mark parity with parity bit 1 and stops 1,1 -> data_vld=1.
- frame_start after 4 data bits, then a full clean frame 0x0F -> exactly one frame_done, P_DATA=0x0F, counters unchanged.
- 256 consecutive parity-error frames with CNT_WIDTH=8 -> par_err_cnt holds 0xFF. clr_sts in the same cycle as an error pulse -> par_err_cnt=1, sts_par_err=1.
- DATA_WIDTH=5, PAR_EN=0, RST asserted after 3 bits, then a clean frame 0x15 -> no pulse during reset, all outputs 0; then P_DATA=0x15, data_vld=1.
